// File: rtl/mul_pkg.sv
// Shared definitions for the iterative radix-4 Booth multiplier.
// Holds the sequencer state enum, Booth triplet encodings and the helpers
// that derive the step count and step-counter width from the operand width.
// No ports.
package mul_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  // Booth radix-4 triplet encodings {b[2i+1], b[2i], b[2i-1]}
  localparam logic [2:0] TripZeroLo = 3'b000;
  localparam logic [2:0] TripPosA0  = 3'b001;
  localparam logic [2:0] TripPosA1  = 3'b010;
  localparam logic [2:0] TripPos2A  = 3'b011;
  localparam logic [2:0] TripNeg2A  = 3'b100;
  localparam logic [2:0] TripNegA0  = 3'b101;
  localparam logic [2:0] TripNegA1  = 3'b110;
  localparam logic [2:0] TripZeroHi = 3'b111;

  localparam int unsigned DefaultWidth = 32;

  // One partial product is retired per step, two multiplier bits each.
  function automatic int unsigned num_steps(input int unsigned width);
    return width / 2;
  endfunction

  function automatic int unsigned step_width(input int unsigned width);
    return (width / 2 > 2) ? $clog2(width / 2) : 1;
  endfunction

  localparam int unsigned NumSteps = num_steps(DefaultWidth);
  localparam int unsigned StepW    = step_width(DefaultWidth);

endpackage

// File: rtl/booth_mul_sequencer_if.sv
// Start/busy/done handshake and operand/result bus of the Booth multiplier.
//   master: control unit side (drives start, a, b; observes busy, done, z)
//   slave:  multiplier side
interface booth_mul_sequencer_if #(
  parameter int unsigned Width = 32
) ();
  logic                 start;
  logic [Width-1:0]     a;
  logic [Width-1:0]     b;
  logic                 busy;
  logic                 done;
  logic [2*Width-1:0]   z;

  modport master (output start, a, b, input busy, done, z);
  modport slave  (input start, a, b, output busy, done, z);
endinterface

// File: rtl/booth_pp_select.sv
// Combinational radix-4 Booth partial-product selector.
//   mcand_i   : sign-extended multiplicand, Width+1 bits
//   triplet_i : Booth triplet {b[2i+1], b[2i], b[2i-1]}
//   pp_o      : selected partial product, Width+2 bits signed
// Width+2 bits keep -2a exact for a = -2^(Width-1).
module booth_pp_select
  import mul_pkg::*;
#(
  parameter int unsigned Width = 32
) (
  input  logic [Width:0]   mcand_i,
  input  logic [2:0]       triplet_i,
  output logic [Width+1:0] pp_o
);
  logic [Width+1:0] pos_a, pos_2a;

  always_comb begin
    pos_a  = {mcand_i[Width], mcand_i};
    pos_2a = {mcand_i, 1'b0};
    pp_o   = '0;
    unique case (triplet_i)
      TripZeroLo, TripZeroHi: pp_o = '0;
      TripPosA0, TripPosA1:   pp_o = pos_a;
      TripPos2A:              pp_o = pos_2a;
      TripNeg2A:              pp_o = -pos_2a;
      TripNegA0, TripNegA1:   pp_o = -pos_a;
      default:                pp_o = '0;
    endcase
  end
endmodule

// File: rtl/booth_mul_sequencer.sv
// Iterative radix-4 Booth multiplier: one partial product per clock.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   bus (slave)  : start/a/b in, busy/done/z out; z = signed a*b, 2*Width bits
// Optional feature: define MUL_EARLY_TERM_EN to finish as soon as the
// remaining multiplier bits can only select zero partial products.
module booth_mul_sequencer
  import mul_pkg::*;
#(
  parameter int unsigned Width = DefaultWidth
) (
  input  logic                  clock,
  input  logic                  reset,
  booth_mul_sequencer_if.slave  bus
);
  localparam int unsigned Steps = num_steps(Width);
  localparam int unsigned SW    = step_width(Width);

  state_e               state_q, state_d;
  logic [Width:0]       mcand_q, mcand_d;
  logic [Width+1:0]     mplier_q, mplier_d;
  logic [2*Width-1:0]   acc_q, acc_d;
  logic [SW-1:0]        step_q, step_d;
  logic [2*Width-1:0]   z_q, z_d;

  logic [Width+1:0]     pp;
  logic [2*Width-1:0]   pp_ext, acc_sum;
  logic [Width+1:0]     mplier_shr;
  logic                 last_step;

  booth_pp_select #(
    .Width (Width)
  ) u_pp_select (
    .mcand_i   (mcand_q),
    .triplet_i (mplier_q[2:0]),
    .pp_o      (pp)
  );

  always_comb begin
    state_d    = state_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    acc_d      = acc_q;
    step_d     = step_q;
    z_d        = z_q;
    last_step  = 1'b0;
    pp_ext     = {{(Width-2){pp[Width+1]}}, pp};
    // Weight of step i is 4^i; the sum wraps modulo 2^(2*Width).
    acc_sum    = acc_q + (pp_ext << {step_q, 1'b0});
    mplier_shr = {{2{mplier_q[Width+1]}}, mplier_q[Width+1:2]};

    unique case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          state_d  = StRun;
          mcand_d  = {bus.a[Width-1], bus.a};
          mplier_d = {bus.b[Width-1], bus.b, 1'b0};
          acc_d    = '0;
          step_d   = '0;
        end else begin
          state_d  = StIdle;
        end
      end
      StRun: begin
        acc_d     = acc_sum;
        mplier_d  = mplier_shr;
        step_d    = step_q + SW'(1);
        last_step = (step_q == SW'(Steps - 1));
`ifdef MUL_EARLY_TERM_EN
        // All-zero or all-one remainder only ever yields zero triplets.
        last_step = last_step || (mplier_shr == '0) || (&mplier_shr);
`endif
        if (last_step) begin
          state_d = StDone;
          z_d     = acc_sum;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      step_q   <= '0;
      z_q      <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      step_q   <= step_d;
      z_q      <= z_d;
    end
  end

  assign bus.busy = (state_q == StRun);
  assign bus.done = (state_q == StDone);
  assign bus.z    = z_q;

endmodule
